mem_responder: RTL

Memory-side responder for the VeriRISC bus. It answers the `rd`/`wr`/`data_e` strobes issued by the CPU controller, and holds a single-port 2^AW x DW program/data store. It also provides a preload port so a testbench or boot loader can fill memory while the CPU is idle. It sits between the address mux (`sel`-selected PC/IR address) and the data bus.

---
 rtl/mem_responder_if.sv | 33 +++
 rtl/mem_responder.sv | 99 +++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Bundles the controller strobes, data bus and preload port of the memory responder.
// Latency: none (wires only).
// Backpressure: ld_ready is driven by the slave; the master holds ld_* until accepted.
interface mem_responder_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic          data_e;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          bus_err;
    logic [1:0]    state;

    // CPU controller / preload requester side
    modport master (
        output addr, rd, wr, data_e, data_in, ld_valid, ld_addr, ld_data,
        input  data_out, data_valid, ld_ready, bus_err, state
    );

    // Memory side
    modport slave (
        input  addr, rd, wr, data_e, data_in, ld_valid, ld_addr, ld_data,
        output data_out, data_valid, ld_ready, bus_err, state
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port program/data store answering rd/wr strobes, with a preload port.
// Latency: reads 1 cycle (registered data_out); writes and preloads commit at the sampling edge.
// Backpressure: preload stalls (ld_ready=0) whenever rd or wr is active; the bus itself never stalls.
module mem_responder #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        LOAD  = 2'd3
    } state_t;

    // Storage is deliberately left unreset so contents survive rst.
    logic [DW-1:0] mem_q [0:DEPTH-1];

    state_t        state_q,      state_d;
    logic [DW-1:0] data_out_q,   data_out_d;
    logic          data_valid_q, data_valid_d;
    logic          bus_err_q,    bus_err_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          ld_ready;

    // Per-cycle arbitration: rd&wr error, then write, then read, then preload, else idle.
    always_comb begin
        state_d      = IDLE;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        bus_err_d    = bus_err_q;
        mem_we       = 1'b0;
        mem_waddr    = bus.addr;
        mem_wdata    = bus.data_in;
        ld_ready     = !bus.rd && !bus.wr;

        if (bus.rd && bus.wr) begin
            // Collision of strobes is a protocol error; the write still lands if data is driven.
            bus_err_d = 1'b1;
            mem_we    = bus.data_e;
            state_d   = WRITE;
        end else if (bus.wr) begin
            // A write strobe without the CPU driving the bus has no valid data to store.
            if (bus.data_e) begin
                mem_we = 1'b1;
            end else begin
                bus_err_d = 1'b1;
            end
            state_d = WRITE;
        end else if (bus.rd) begin
            data_out_d   = mem_q[bus.addr];
            data_valid_d = 1'b1;
            state_d      = READ;
        end else if (bus.ld_valid) begin
            // ld_ready is necessarily high here, so the request is accepted.
            mem_we    = 1'b1;
            mem_waddr = bus.ld_addr;
            mem_wdata = bus.ld_data;
            state_d   = LOAD;
        end
    end

    // Output and state registers; reset overrides any bus activity in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Array write port; suppressed during reset so no write or preload commits.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.bus_err    = bus_err_q;
    assign bus.state      = state_q;
    assign bus.ld_ready   = ld_ready;

endmodule
